// File: rtl/mux_4to1_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_4to1_arbiter
// Purpose  : Round-robin arbiter driving a dual-rail select for a shared 4:1
//            mux, with a settling cycle before each grant and timeout preemption.
// Revision : 1.0 - initial release
// ============================================================================
module mux_4to1_arbiter #(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       Clk,
  input  logic       _Reset,
  input  logic [3:0] Req,
  output logic [3:0] Grant,
  output logic [1:0] Select,
  output logic [1:0] _Select,
  output logic       Valid,
  output logic       Preempt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SWITCH = 2'd1,
    S_GRANT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic             C_PREEMPT   = (HOLD_MAX != 0);

  state_t           r_state;
  logic [1:0]       r_win;
  logic [1:0]       r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_grant;
  logic [1:0]       r_sel;
  logic [1:0]       r_sel_n;
  logic             r_valid;
  logic             r_preempt;

  state_t           w_state;
  logic [1:0]       w_win;
  logic [1:0]       w_last;
  logic [CNT_W-1:0] w_cnt;
  logic [3:0]       w_grant;
  logic [1:0]       w_sel;
  logic             w_valid;
  logic             w_preempt;

  logic [3:0]       w_win_oh;
  logic [3:0]       w_others;
  logic [1:0]       w_pick_idle;
  logic [1:0]       w_pick_next;

  // First set bit of req, scanning upward from start and wrapping.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign w_win_oh    = 4'b0001 << r_win;
  assign w_others    = Req & ~w_win_oh;
  assign w_pick_idle = rr_pick(Req, r_last + 2'd1);
  assign w_pick_next = rr_pick(w_others, r_win + 2'd1);

  always_comb begin
    w_state   = r_state;
    w_win     = r_win;
    w_last    = r_last;
    w_cnt     = r_cnt;
    w_grant   = r_grant;
    w_sel     = r_sel;
    w_valid   = r_valid;
    w_preempt = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_grant = 4'b0000;
        w_valid = 1'b0;
        if (|Req) begin
          w_win   = w_pick_idle;
          w_sel   = w_pick_idle;
          w_state = S_SWITCH;
        end
      end

      S_SWITCH: begin
        if (Req[r_win]) begin
          w_state = S_GRANT;
          w_grant = w_win_oh;
          w_valid = 1'b1;
          w_cnt   = '0;
        end else begin
          w_state = S_IDLE;
        end
      end

      S_GRANT: begin
        if (r_cnt != C_CNT_MAX) begin
          w_cnt = r_cnt + 1'b1;
        end
        // Release takes precedence over a coincident timeout.
        if (!Req[r_win]) begin
          w_grant = 4'b0000;
          w_valid = 1'b0;
          w_last  = r_win;
          if (|w_others) begin
            w_win   = w_pick_next;
            w_sel   = w_pick_next;
            w_state = S_SWITCH;
          end else begin
            w_state = S_IDLE;
          end
        end else if (C_PREEMPT && (r_cnt == C_HOLD_LAST) && (|w_others)) begin
          w_grant   = 4'b0000;
          w_valid   = 1'b0;
          w_preempt = 1'b1;
          w_last    = r_win;
          w_win     = w_pick_next;
          w_sel     = w_pick_next;
          w_state   = S_SWITCH;
        end
      end

      default: begin
        w_state = S_IDLE;
        w_grant = 4'b0000;
        w_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge _Reset) begin
    if (!_Reset) begin
      r_state   <= S_IDLE;
      r_win     <= 2'd0;
      r_last    <= 2'd3;
      r_cnt     <= '0;
      r_grant   <= 4'b0000;
      r_sel     <= 2'b00;
      r_sel_n   <= 2'b11;
      r_valid   <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_win     <= w_win;
      r_last    <= w_last;
      r_cnt     <= w_cnt;
      r_grant   <= w_grant;
      r_sel     <= w_sel;
      r_sel_n   <= ~w_sel;
      r_valid   <= w_valid;
      r_preempt <= w_preempt;
    end
  end

  assign Grant   = r_grant;
  assign Select  = r_sel;
  assign _Select = r_sel_n;
  assign Valid   = r_valid;
  assign Preempt = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_mux_4to1_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_4to1_arbiter
// Purpose  : Directed vector bench for mux_4to1_arbiter (default and short hold).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_4to1_arbiter;

  logic       clk;
  logic       rstn;
  logic [3:0] req,  req4;
  logic [3:0] grant, grant4;
  logic [1:0] sel, sel4, sel_n, sel_n4;
  logic       valid, valid4, preempt, preempt4;

  int checks;
  int errors;

  typedef struct {
    logic       rstn;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic       preempt;
  } vec_t;

  vec_t tbl[$];
  vec_t tbl4[$];

  mux_4to1_arbiter dut (
    .Clk(clk), ._Reset(rstn), .Req(req), .Grant(grant), .Select(sel),
    ._Select(sel_n), .Valid(valid), .Preempt(preempt)
  );

  mux_4to1_arbiter #(.HOLD_MAX(4), .CNT_W(3)) dut4 (
    .Clk(clk), ._Reset(rstn), .Req(req4), .Grant(grant4), .Select(sel4),
    ._Select(sel_n4), .Valid(valid4), .Preempt(preempt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rail complement and Valid/Grant consistency on every cycle.
  always @(negedge clk) begin
    logic [1:0] inv;
    logic [1:0] inv4;
    inv  = ~sel;
    inv4 = ~sel4;
    chk("rail", {6'd0, sel_n}, {6'd0, inv});
    chk("rail4", {6'd0, sel_n4}, {6'd0, inv4});
    chk("valid_or", {7'd0, valid}, {7'd0, |grant});
    chk("valid_or4", {7'd0, valid4}, {7'd0, |grant4});
  end

  task automatic run_vec(input vec_t v, input bit use4, input int idx);
    logic [3:0] g;
    logic [1:0] s;
    logic       vl, p;
    rstn = v.rstn;
    if (use4) req4 = v.req; else req = v.req;
    tick();
    g  = use4 ? grant4   : grant;
    s  = use4 ? sel4     : sel;
    vl = use4 ? valid4   : valid;
    p  = use4 ? preempt4 : preempt;
    chk($sformatf("%s v%0d grant",   use4 ? "h4" : "h16", idx), {4'd0, g},  {4'd0, v.grant});
    chk($sformatf("%s v%0d select",  use4 ? "h4" : "h16", idx), {6'd0, s},  {6'd0, v.sel});
    chk($sformatf("%s v%0d valid",   use4 ? "h4" : "h16", idx), {7'd0, vl}, {7'd0, v.valid});
    chk($sformatf("%s v%0d preempt", use4 ? "h4" : "h16", idx), {7'd0, p},  {7'd0, v.preempt});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    req  = 4'b0000;
    req4 = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst grant",   {4'd0, grant},   8'h00);
    chk("rst select",  {6'd0, sel},     8'h00);
    chk("rst select_n",{6'd0, sel_n},   8'h03);
    chk("rst valid",   {7'd0, valid},   8'h00);
    chk("rst preempt", {7'd0, preempt}, 8'h00);
    chk("rst grant4",  {4'd0, grant4},  8'h00);
    chk("rst select_n4",{6'd0, sel_n4}, 8'h03);
    rstn = 1'b1;

    //           rstn  req      grant    sel    valid preempt
    // basic grant latency and release
    tbl.push_back('{1'b1, 4'b0001, 4'b0000, 2'b00, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0});
    // request withdrawn during the settling cycle
    tbl.push_back('{1'b1, 4'b0010, 4'b0000, 2'b01, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 2'b01, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'b0011, 4'b0000, 2'b00, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'b0011, 4'b0001, 2'b00, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 4'b0010, 4'b0000, 2'b01, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'b0010, 4'b0010, 2'b01, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 2'b01, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0});
    // full rotation, each requester releasing after three grant cycles
    tbl.push_back('{1'b1, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0});
    for (int r = 0; r < 4; r++) begin
      logic [3:0] oh;
      logic [1:0] nx;
      oh = 4'b0001 << r;
      nx = 2'(r + 1);
      for (int k = 0; k < 3; k++)
        tbl.push_back('{1'b1, 4'b1111, oh, 2'(r), 1'b1, 1'b0});
      tbl.push_back('{1'b1, 4'b1111 & ~oh, 4'b0000, nx, 1'b0, 1'b0});
    end
    tbl.push_back('{1'b1, 4'b1111, 4'b0001, 2'b00, 1'b1, 1'b0});

    foreach (tbl[i]) run_vec(tbl[i], 1'b0, i);

    // HOLD_MAX=4 preemption ping-pong between 0 and 1
    tbl4.push_back('{1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0});
    tbl4.push_back('{1'b1, 4'b0011, 4'b0000, 2'b00, 1'b0, 1'b0});
    for (int k = 0; k < 4; k++)
      tbl4.push_back('{1'b1, 4'b0011, 4'b0001, 2'b00, 1'b1, 1'b0});
    tbl4.push_back('{1'b1, 4'b0011, 4'b0000, 2'b01, 1'b0, 1'b1});
    for (int k = 0; k < 4; k++)
      tbl4.push_back('{1'b1, 4'b0011, 4'b0010, 2'b01, 1'b1, 1'b0});
    tbl4.push_back('{1'b1, 4'b0011, 4'b0000, 2'b00, 1'b0, 1'b1});
    tbl4.push_back('{1'b1, 4'b0011, 4'b0001, 2'b00, 1'b1, 1'b0});

    foreach (tbl4[i]) run_vec(tbl4[i], 1'b1, i);

    // Lone requester is never preempted, however long it holds
    rstn = 1'b0;
    req4 = 4'b0000;
    tick();
    rstn = 1'b1;
    req4 = 4'b0100;
    tick();
    chk("lone switch grant", {4'd0, grant4}, 8'h00);
    chk("lone switch sel",   {6'd0, sel4},   8'h02);
    for (int c = 0; c < 40; c++) begin
      tick();
      chk($sformatf("lone c%0d grant", c),   {4'd0, grant4},   8'h04);
      chk($sformatf("lone c%0d preempt", c), {7'd0, preempt4}, 8'h00);
    end
    req4 = 4'b0000;

    // Asynchronous reset in the middle of a grant
    rstn = 1'b0;
    req  = 4'b0000;
    tick();
    rstn = 1'b1;
    req  = 4'b0010;
    tick();
    tick();
    req  = 4'b0000;
    tick();
    req  = 4'b0100;
    tick();
    tick();
    chk("pre-rst grant",  {4'd0, grant}, 8'h04);
    chk("pre-rst select", {6'd0, sel},   8'h02);
    #2;
    rstn = 1'b0;
    #2;
    chk("async grant",    {4'd0, grant}, 8'h00);
    chk("async valid",    {7'd0, valid}, 8'h00);
    chk("async select",   {6'd0, sel},   8'h00);
    chk("async select_n", {6'd0, sel_n}, 8'h03);
    #1;
    rstn = 1'b1;
    req  = 4'b1111;
    tick();
    chk("restart select", {6'd0, sel},   8'h00);
    tick();
    chk("restart grant",  {4'd0, grant}, 8'h01);
    req = 4'b0000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
